cla_pipelined_approx_adder: RTL and testbench

- Parametrised, pipelined N-bit carry-lookahead adder built from 4-bit lookahead groups.
- The carry ripples between groups through pipeline registers, so each stage resolves GROUPS_PER_STAGE groups.
- Adds a per-transaction, runtime-selectable approximate lower part: the low k bits are OR-ed, and a carry is speculated from bit k-1.
- Sits between the operand source and the error-metric / accumulator logic of the approximate-adder test fabric, using valid/ready on both sides.

---
 rtl/cla_pipelined_approx_adder.sv | 139 +++++++++++++
 tb/tb_cla_pipelined_approx_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipelined_approx_adder.sv
// Pipelined carry-lookahead adder with a runtime-selectable approximate low part.
// Each stage resolves GROUPS_PER_STAGE 4-bit lookahead groups; the inter-group carry is registered between stages.
module cla_pipelined_approx_adder #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned GROUPS_PER_STAGE = 1,
  parameter int unsigned APPROX_MAX       = 8,
  parameter int unsigned KW               = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [KW-1:0]    approx_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [KW-1:0]    out_k
);

  localparam int unsigned SW = 4 * GROUPS_PER_STAGE;
  localparam int unsigned L  = WIDTH / SW;

  logic          adv;
  logic [KW-1:0] k_cl;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign k_cl     = (32'(approx_k) > APPROX_MAX) ? KW'(APPROX_MAX) : approx_k;

  assign out_valid = g_stage[L-1].rv;
  assign sum       = g_stage[L-1].rsum;
  assign cout      = g_stage[L-1].rc;
  assign out_k     = g_stage[L-1].rk;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int unsigned IW  = WIDTH - s * SW;
    localparam int unsigned LSB = s * SW;

    logic             iv;
    logic [IW-1:0]    ia;
    logic [IW-1:0]    ib;
    logic [WIDTH-1:0] isum;
    logic             ic;
    logic [KW-1:0]    ik;

    logic             rv;
    logic [WIDTH-1:0] rsum;
    logic             rc;
    logic [KW-1:0]    rk;

    logic [GROUPS_PER_STAGE:0] gc;
    logic [SW-1:0]             gsum;
    logic [WIDTH-1:0]          nsum;

    // Stage source: the ports for stage 0, the previous stage register otherwise.
    if (s == 0) begin : g_src
      assign iv   = in_valid;
      assign ia   = a;
      assign ib   = b;
      assign isum = '0;
      assign ik   = k_cl;
      assign ic   = (k_cl == '0) ? cin : 1'b0;
    end else begin : g_src
      assign iv   = g_stage[s-1].rv;
      assign ia   = g_stage[s-1].g_rem.ra;
      assign ib   = g_stage[s-1].g_rem.rb;
      assign isum = g_stage[s-1].rsum;
      assign ik   = g_stage[s-1].rk;
      assign ic   = g_stage[s-1].rc;
    end

    assign gc[0] = ic;

    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      localparam int unsigned LB = 4 * j;
      logic [3:0] pm;
      logic [3:0] gm;
      logic [3:0] c;

      // Bits below k propagate nothing; bit k-1 still generates, which is the speculated carry.
      for (genvar i = 0; i < 4; i++) begin : g_bit
        localparam int unsigned N = LSB + LB + i;
        assign pm[i]        = (32'(ik) <= N)     ? (ia[LB+i] ^ ib[LB+i]) : 1'b0;
        assign gm[i]        = (32'(ik) <= N + 1) ? (ia[LB+i] & ib[LB+i]) : 1'b0;
        assign gsum[LB+i]   = (32'(ik) > N)      ? (ia[LB+i] | ib[LB+i]) : (pm[i] ^ c[i]);
      end

      assign c[0]    = gc[j];
      assign c[1]    = gm[0] | (pm[0] & c[0]);
      assign c[2]    = gm[1] | (pm[1] & gm[0]) | (pm[1] & pm[0] & c[0]);
      assign c[3]    = gm[2] | (pm[2] & gm[1]) | (pm[2] & pm[1] & gm[0])
                     | (pm[2] & pm[1] & pm[0] & c[0]);
      assign gc[j+1] = gm[3] | (pm[3] & gm[2]) | (pm[3] & pm[2] & gm[1])
                     | (pm[3] & pm[2] & pm[1] & gm[0])
                     | (pm[3] & pm[2] & pm[1] & pm[0] & c[0]);
    end

    always_comb begin
      nsum          = isum;
      nsum[LSB+:SW] = gsum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rv   <= 1'b0;
        rsum <= '0;
        rc   <= 1'b0;
        rk   <= '0;
      end else if (adv) begin
        rv <= iv;
        if (iv) begin
          rsum <= nsum;
          rc   <= gc[GROUPS_PER_STAGE];
          rk   <= ik;
        end
      end
    end

    // Operand bits not yet consumed travel on to later stages.
    if (s < L - 1) begin : g_rem
      logic [IW-SW-1:0] ra;
      logic [IW-SW-1:0] rb;
      always_ff @(posedge clk) begin
        if (rst) begin
          ra <= '0;
          rb <= '0;
        end else if (adv && iv) begin
          ra <= ia[IW-1:SW];
          rb <= ib[IW-1:SW];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipelined_approx_adder.sv
// Scoreboard bench for cla_pipelined_approx_adder: directed corner cases, backpressure, reset and random traffic.
module tb_cla_pipelined_approx_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [3:0]  approx_k;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  out_k;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic [3:0]  k;
    int          t;
    bit          lat;
  } exp_t;

  exp_t q[$];

  cla_pipelined_approx_adder #(
    .WIDTH(16), .GROUPS_PER_STAGE(1), .APPROX_MAX(8), .KW(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_k(approx_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .out_k(out_k)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: OR below k, speculated carry from bit k-1, plain addition above.
  function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb,
                                 input logic xc, input logic [3:0] xk);
    exp_t        r;
    int unsigned kc;
    int unsigned ua;
    int unsigned ub;
    int unsigned full;
    int unsigned hi;
    int unsigned spec;
    kc = (xk > 4'd8) ? 8 : 32'(xk);
    ua = 32'(xa);
    ub = 32'(xb);
    if (kc == 0) begin
      full = ua + ub + 32'(xc);
    end else begin
      spec = ((ua >> (kc - 1)) & (ub >> (kc - 1))) & 1;
      hi   = (ua >> kc) + (ub >> kc) + spec;
      full = (hi << kc) | ((ua | ub) & ((32'd1 << kc) - 1));
    end
    r.s   = 16'(full);
    r.c   = ((full >> 16) & 1) != 0;
    r.k   = 4'(kc);
    r.t   = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  task automatic push_exp(input bit lat);
    exp_t e;
    e     = model(a, b, cin, approx_k);
    e.t   = cyc;
    e.lat = lat;
    q.push_back(e);
  endtask

  // Monitor: compares the presented result with the scoreboard head every cycle it is valid.
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: sum=%h cout=%b k=%0d with nothing expected", sum, cout, out_k);
        end else begin
          if (sum !== q[0].s || cout !== q[0].c || out_k !== q[0].k) begin
            errors++;
            $display("FAIL result: got sum=%h cout=%b k=%0d want sum=%h cout=%b k=%0d",
                     sum, cout, out_k, q[0].s, q[0].c, q[0].k);
          end
          if (q[0].lat && !seen) begin
            checks++;
            if (cyc - q[0].t != 4) begin
              errors++;
              $display("FAIL latency: got %0d want 4", cyc - q[0].t);
            end
          end
          seen = 1'b1;
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                       input logic [3:0] xk, input bit lat);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; a = xa; b = xb; cin = xc; approx_k = xk;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        push_exp(lat);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout: beat a=%h b=%h not accepted", xa, xb);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 60 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    int idx;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; approx_k = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || out_k !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b sum=%h cout=%b k=%0d in_ready=%b",
               out_valid, sum, cout, out_k, in_ready);
    end
    @(posedge clk); #1;

    // Directed corners, each with an empty pipe so latency is checked.
    issue(16'hFFFF, 16'h0001, 1'b0, 4'd0, 1'b1);  drain();
    issue(16'hFFFF, 16'h0000, 1'b1, 4'd0, 1'b1);  drain();
    issue(16'h000F, 16'h0001, 1'b0, 4'd4, 1'b1);  drain();
    issue(16'h000F, 16'h0001, 1'b0, 4'd0, 1'b1);  drain();
    issue(16'h0008, 16'h0008, 1'b1, 4'd4, 1'b1);  drain();
    issue(16'h0008, 16'h0008, 1'b1, 4'd15, 1'b1); drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 4'd8, 1'b1);  drain();
    issue(16'h8000, 16'h8000, 1'b1, 4'd0, 1'b1);  drain();

    // Backpressure: 8 back-to-back beats, downstream stalls on cycles 6..9.
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid = 1'b1; a = 16'(idx); b = 16'(idx); cin = 1'b0; approx_k = 4'd0;
      @(negedge clk);
      if (c >= 6 && c <= 9) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: cycle %0d in_ready=%b want 0", c, in_ready);
        end
      end
      if (in_ready) begin
        push_exp(1'b0);
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 8) begin
      errors++;
      $display("FAIL stream_count: accepted %0d want 8", idx);
    end
    drain();

    // Reset with three beats in flight; nothing stale may emerge.
    issue(16'h1111, 16'h0001, 1'b0, 4'd0, 1'b0);
    in_valid = 1'b1;
    issue(16'h2222, 16'h0002, 1'b0, 4'd0, 1'b0);
    issue(16'h3333, 16'h0003, 1'b0, 4'd0, 1'b0);
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_valid: cycle %0d out_valid=%b want 0", n, out_valid);
      end
      @(posedge clk); #1;
    end
    issue(16'h1234, 16'h1111, 1'b0, 4'd0, 1'b1);
    drain();

    // Random traffic with random valid/ready.
    for (int n = 0; n < 12000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); approx_k = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (in_valid && in_ready) push_exp(1'b0);
      @(posedge clk); #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
